// File: rtl/ariane_pkg.sv
// Shared types for the RoCC dispatcher: command bundle and tag width.
// Optional perf counters in rocc_dispatch are enabled by ROCC_DISPATCH_PERF_EN.
package ariane_pkg;

  localparam int unsigned TRANS_ID_BITS = 3;

  typedef struct packed {
    logic [31:0]              instr;
    logic [63:0]              rs1;
    logic [63:0]              rs2;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } rocc_cmd_t;

  // xd: the instruction expects a destination-register response
  function automatic logic rocc_xd(input logic [31:0] instr);
    return instr[14];
  endfunction

endpackage

// File: rtl/rocc_cmd_fifo.sv
// Power-of-two command FIFO holding rocc_cmd_t entries.
// Flush empties it in one cycle; push when full and pop when empty are ignored.
module rocc_cmd_fifo
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      flush_i,
  input  logic      push_i,
  input  rocc_cmd_t data_i,
  input  logic      pop_i,
  output rocc_cmd_t data_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  rocc_cmd_t      mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign data_o  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_i && !full_o)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_i && !empty_o)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o)
      mem[wr_ptr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/rocc_dispatch.sv
// RoCC dispatcher: command FIFO, in-order response tag queue, flush drain FSM.
// Define ROCC_DISPATCH_PERF_EN to build the command/stall performance counters.
module rocc_dispatch
  import ariane_pkg::*;
#(
  parameter int unsigned CMD_DEPTH = 2,
  parameter int unsigned MAX_OUT   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     rocc_valid_i,
  output logic                     rocc_ready_o,
  input  logic [31:0]              rocc_instr_i,
  input  logic [63:0]              rs1_i,
  input  logic [63:0]              rs2_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic [31:0]              cmd_instr_o,
  output logic [63:0]              cmd_rs1_o,
  output logic [63:0]              cmd_rs2_o,
  input  logic                     resp_valid_i,
  output logic                     resp_ready_o,
  input  logic [63:0]              resp_data_i,
  output logic                     wb_valid_o,
  output logic [63:0]              wb_data_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic                     busy_o,
  output logic [31:0]              perf_cmd_o,
  output logic [31:0]              perf_stall_o
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  localparam int unsigned CW = $clog2(MAX_OUT + 1);
  localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [0:0]   state, state_nxt;
  logic         armed;
  logic         run;
  logic         fifo_full, fifo_empty;
  logic         push, cmd_fire, resp_fire;
  logic         head_xd, tag_push, tag_pop;
  logic         nx_pend;
  logic [CW-1:0] out_cnt, out_cnt_nxt;
  logic [PW-1:0] tag_wr, tag_rd;
  logic [TRANS_ID_BITS-1:0] nx_tag;
  logic [TRANS_ID_BITS-1:0] tag_q [MAX_OUT];
  rocc_cmd_t    in_cmd, head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_cmd = '{instr: rocc_instr_i, rs1: rs1_i,
                    rs2: rs2_i, trans_id: trans_id_i};

  rocc_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  (in_cmd),
    .pop_i   (cmd_fire),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // armed keeps both ready outputs low in the first cycle out of reset
  assign run          = (state == RUN);
  assign head_xd      = rocc_xd(head.instr);
  assign rocc_ready_o = armed && run && !fifo_full && !flush_i;
  assign push         = rocc_valid_i && rocc_ready_o;
  assign cmd_valid_o  = run && !fifo_empty &&
                        !(head_xd && out_cnt == CW'(MAX_OUT));
  assign cmd_fire     = cmd_valid_o && cmd_ready_i;
  assign cmd_instr_o  = cmd_valid_o ? head.instr : '0;
  assign cmd_rs1_o    = cmd_valid_o ? head.rs1 : '0;
  assign cmd_rs2_o    = cmd_valid_o ? head.rs2 : '0;
  assign resp_ready_o = armed && (run ? !nx_pend : 1'b1);
  assign resp_fire    = resp_valid_i && resp_ready_o;
  assign tag_push     = cmd_fire && head_xd;
  assign tag_pop      = resp_fire && (out_cnt != '0);
  assign out_cnt_nxt  = out_cnt + CW'(tag_push) - CW'(tag_pop);
  assign busy_o       = !fifo_empty || (out_cnt != '0) ||
                        nx_pend || (state == DRAIN);

  always_comb begin
    wb_valid_o    = 1'b0;
    wb_data_o     = '0;
    wb_trans_id_o = '0;
    if (run && nx_pend) begin
      wb_valid_o    = 1'b1;
      wb_trans_id_o = nx_tag;
    end else if (run && tag_pop) begin
      wb_valid_o    = 1'b1;
      wb_data_o     = resp_data_i;
      wb_trans_id_o = tag_q[tag_rd];
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == RUN):
        if (flush_i && out_cnt_nxt != '0) state_nxt = DRAIN;
      (state == DRAIN):
        if (out_cnt_nxt == '0) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= RUN;
      armed   <= 1'b0;
      out_cnt <= '0;
      tag_wr  <= '0;
      tag_rd  <= '0;
      nx_pend <= 1'b0;
      nx_tag  <= '0;
    end else begin
      state   <= state_nxt;
      armed   <= 1'b1;
      out_cnt <= out_cnt_nxt;
      if (tag_push) tag_wr <= ptr_inc(tag_wr);
      if (tag_pop)  tag_rd <= ptr_inc(tag_rd);
      if (flush_i) begin
        nx_pend <= 1'b0;
      end else if (cmd_fire && !head_xd) begin
        nx_pend <= 1'b1;
        nx_tag  <= head.trans_id;
      end else if (run) begin
        nx_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (tag_push) tag_q[tag_wr] <= head.trans_id;
  end

`ifdef ROCC_DISPATCH_PERF_EN
  logic [31:0] perf_cmd_q, perf_stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_cmd_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (cmd_fire) perf_cmd_q <= perf_cmd_q + 1'b1;
      if (cmd_valid_o && !cmd_ready_i)
        perf_stall_q <= perf_stall_q + 1'b1;
    end
  end

  assign perf_cmd_o   = perf_cmd_q;
  assign perf_stall_o = perf_stall_q;
`else
  assign perf_cmd_o   = '0;
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_rocc_dispatch.sv
// Self-checking bench for rocc_dispatch: vector table plus directed
// sequences for back-pressure, MAX_OUT, flush drain, reset and perf counters.
module tb_rocc_dispatch;
  import ariane_pkg::*;

  localparam logic [31:0] IX1 = 32'h0000_400B;
  localparam logic [31:0] IX0 = 32'h0000_200B;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i;
  logic        rocc_valid_i, rocc_ready_o;
  logic [31:0] rocc_instr_i;
  logic [63:0] rs1_i, rs2_i;
  logic [TRANS_ID_BITS-1:0] trans_id_i;
  logic        cmd_valid_o, cmd_ready_i;
  logic [31:0] cmd_instr_o;
  logic [63:0] cmd_rs1_o, cmd_rs2_o;
  logic        resp_valid_i, resp_ready_o;
  logic [63:0] resp_data_i;
  logic        wb_valid_o;
  logic [63:0] wb_data_o;
  logic [TRANS_ID_BITS-1:0] wb_trans_id_o;
  logic        busy_o;
  logic [31:0] perf_cmd_o, perf_stall_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  rocc_dispatch dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .rocc_valid_i(rocc_valid_i), .rocc_ready_o(rocc_ready_o),
    .rocc_instr_i(rocc_instr_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .trans_id_i(trans_id_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_instr_o(cmd_instr_o), .cmd_rs1_o(cmd_rs1_o),
    .cmd_rs2_o(cmd_rs2_o),
    .resp_valid_i(resp_valid_i), .resp_ready_o(resp_ready_o),
    .resp_data_i(resp_data_i),
    .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o),
    .wb_trans_id_o(wb_trans_id_o), .busy_o(busy_o),
    .perf_cmd_o(perf_cmd_o), .perf_stall_o(perf_stall_o)
  );

  typedef struct {
    logic        rv;
    logic [31:0] instr;
    logic [63:0] rs1, rs2;
    logic [2:0]  tid;
    logic        cr, pv;
    logic [63:0] pd;
    logic        e_rr, e_cv;
    logic [31:0] e_ci;
    logic [63:0] e_c1, e_c2;
    logic        e_pr, e_wv;
    logic [63:0] e_wd;
    logic [2:0]  e_wt;
    logic        e_busy;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic offer(input logic [31:0] ins, input logic [63:0] a,
                       input logic [2:0] t);
    rocc_valid_i = 1'b1;
    rocc_instr_i = ins;
    rs1_i        = a;
    rs2_i        = a + 64'd100;
    trans_id_i   = t;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; rocc_valid_i = 1'b0;
    rocc_instr_i = '0; rs1_i = '0; rs2_i = '0; trans_id_i = '0;
    cmd_ready_i = 1'b0; resp_valid_i = 1'b0; resp_data_i = '0;

    tbl[0] = '{1'b1, IX1, 64'd1, 64'd2, 3'd3, 1'b0, 1'b0, 64'd0,
               1'b1, 1'b0, 32'd0, 64'd0, 64'd0,
               1'b1, 1'b0, 64'd0, 3'd0, 1'b0};
    tbl[1] = '{1'b0, 32'd0, 64'd0, 64'd0, 3'd0, 1'b1, 1'b0, 64'd0,
               1'b1, 1'b1, IX1, 64'd1, 64'd2,
               1'b1, 1'b0, 64'd0, 3'd0, 1'b1};
    tbl[2] = '{1'b0, 32'd0, 64'd0, 64'd0, 3'd0, 1'b0, 1'b1, 64'hDEAD,
               1'b1, 1'b0, 32'd0, 64'd0, 64'd0,
               1'b1, 1'b1, 64'hDEAD, 3'd3, 1'b1};
    tbl[3] = '{1'b0, 32'd0, 64'd0, 64'd0, 3'd0, 1'b0, 1'b0, 64'd0,
               1'b1, 1'b0, 32'd0, 64'd0, 64'd0,
               1'b1, 1'b0, 64'd0, 3'd0, 1'b0};
    tbl[4] = '{1'b1, IX0, 64'd7, 64'd8, 3'd5, 1'b0, 1'b0, 64'd0,
               1'b1, 1'b0, 32'd0, 64'd0, 64'd0,
               1'b1, 1'b0, 64'd0, 3'd0, 1'b0};
    tbl[5] = '{1'b0, 32'd0, 64'd0, 64'd0, 3'd0, 1'b1, 1'b0, 64'd0,
               1'b1, 1'b1, IX0, 64'd7, 64'd8,
               1'b1, 1'b0, 64'd0, 3'd0, 1'b1};
    tbl[6] = '{1'b0, 32'd0, 64'd0, 64'd0, 3'd0, 1'b0, 1'b1, 64'hBEEF,
               1'b1, 1'b0, 32'd0, 64'd0, 64'd0,
               1'b0, 1'b1, 64'd0, 3'd5, 1'b1};
    tbl[7] = '{1'b0, 32'd0, 64'd0, 64'd0, 3'd0, 1'b0, 1'b1, 64'hBEEF,
               1'b1, 1'b0, 32'd0, 64'd0, 64'd0,
               1'b1, 1'b0, 64'd0, 3'd0, 1'b0};

    // reset state: every output low in the first cycle out of reset
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rst_rocc_ready", rocc_ready_o, 0);
    chk("rst_cmd_valid", cmd_valid_o, 0);
    chk("rst_cmd_instr", cmd_instr_o, 0);
    chk("rst_cmd_rs1", cmd_rs1_o, 0);
    chk("rst_cmd_rs2", cmd_rs2_o, 0);
    chk("rst_resp_ready", resp_ready_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_wb_data", wb_data_o, 0);
    chk("rst_wb_tid", wb_trans_id_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_perf_cmd", perf_cmd_o, 0);
    chk("rst_perf_stall", perf_stall_o, 0);
    tick();

    // xd=1 round trip, then xd=0 local writeback with stalled response
    for (int i = 0; i < 8; i++) begin
      rocc_valid_i = tbl[i].rv;  rocc_instr_i = tbl[i].instr;
      rs1_i = tbl[i].rs1;        rs2_i = tbl[i].rs2;
      trans_id_i = tbl[i].tid;   cmd_ready_i = tbl[i].cr;
      resp_valid_i = tbl[i].pv;  resp_data_i = tbl[i].pd;
      #1;
      chk($sformatf("v%0d_rocc_ready", i), rocc_ready_o, tbl[i].e_rr);
      chk($sformatf("v%0d_cmd_valid", i), cmd_valid_o, tbl[i].e_cv);
      if (tbl[i].e_cv) begin
        chk($sformatf("v%0d_cmd_instr", i), cmd_instr_o, tbl[i].e_ci);
        chk($sformatf("v%0d_cmd_rs1", i), cmd_rs1_o, tbl[i].e_c1);
        chk($sformatf("v%0d_cmd_rs2", i), cmd_rs2_o, tbl[i].e_c2);
      end
      chk($sformatf("v%0d_resp_ready", i), resp_ready_o, tbl[i].e_pr);
      chk($sformatf("v%0d_wb_valid", i), wb_valid_o, tbl[i].e_wv);
      if (tbl[i].e_wv) begin
        chk($sformatf("v%0d_wb_data", i), wb_data_o, tbl[i].e_wd);
        chk($sformatf("v%0d_wb_tid", i), wb_trans_id_o, tbl[i].e_wt);
      end
      chk($sformatf("v%0d_busy", i), busy_o, tbl[i].e_busy);
      tick();
    end
    rocc_valid_i = 1'b0; resp_valid_i = 1'b0; cmd_ready_i = 1'b0;

    // MAX_OUT limit: fifth xd=1 head waits for a response
    cmd_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(IX1, 64'(i), 3'(i));
      #1 chk($sformatf("mo_rocc_ready%0d", i), rocc_ready_o, 1);
      tick();
    end
    rocc_valid_i = 1'b0;
    #1 chk("mo_hold_a", cmd_valid_o, 0);
    chk("mo_busy", busy_o, 1);
    tick();
    #1 chk("mo_hold_b", cmd_valid_o, 0);
    tick();
    resp_valid_i = 1'b1; resp_data_i = 64'h11;
    #1 chk("mo_wb_valid0", wb_valid_o, 1);
    chk("mo_wb_tid0", wb_trans_id_o, 0);
    chk("mo_wb_data0", wb_data_o, 64'h11);
    chk("mo_hold_c", cmd_valid_o, 0);
    tick();
    resp_valid_i = 1'b0;
    #1 chk("mo_release", cmd_valid_o, 1);
    chk("mo_release_rs1", cmd_rs1_o, 4);
    tick();
    cmd_ready_i = 1'b0;
    for (int k = 1; k < 5; k++) begin
      resp_valid_i = 1'b1; resp_data_i = 64'(k);
      #1 chk($sformatf("mo_wb_valid%0d", k), wb_valid_o, 1);
      chk($sformatf("mo_wb_tid%0d", k), wb_trans_id_o, 64'(k));
      tick();
    end
    resp_valid_i = 1'b0;
    #1 chk("mo_idle_busy", busy_o, 0);

    // FIFO full back-pressure and simultaneous push/pop
    offer(IX0, 64'd10, 3'd2);
    #1 chk("ff_rr0", rocc_ready_o, 1);
    tick();
    offer(IX0, 64'd11, 3'd3);
    #1 chk("ff_rr1", rocc_ready_o, 1);
    chk("ff_head0", cmd_rs1_o, 10);
    tick();
    offer(IX0, 64'd12, 3'd4);
    #1 chk("ff_full", rocc_ready_o, 0);
    chk("ff_cv_stall", cmd_valid_o, 1);
    tick();
    cmd_ready_i = 1'b1;
    #1 chk("ff_full_pop", rocc_ready_o, 0);
    chk("ff_head1", cmd_rs1_o, 10);
    tick();
    #1 chk("ff_pushpop_rr", rocc_ready_o, 1);
    chk("ff_head2", cmd_rs1_o, 11);
    chk("ff_wb_a", wb_valid_o, 1);
    chk("ff_wb_a_tid", wb_trans_id_o, 2);
    tick();
    cmd_ready_i = 1'b0;
    offer(IX0, 64'd13, 3'd5);
    #1 chk("ff_rr_after", rocc_ready_o, 1);
    chk("ff_head3", cmd_rs1_o, 12);
    chk("ff_wb_b_tid", wb_trans_id_o, 3);
    tick();
    rocc_valid_i = 1'b0; cmd_ready_i = 1'b1;
    #1 chk("ff_full_again", rocc_ready_o, 0);
    chk("ff_head4", cmd_rs1_o, 12);
    chk("ff_no_wb", wb_valid_o, 0);
    tick();
    #1 chk("ff_head5", cmd_rs1_o, 13);
    chk("ff_wb_c_tid", wb_trans_id_o, 4);
    tick();
    cmd_ready_i = 1'b0;
    #1 chk("ff_wb_d_tid", wb_trans_id_o, 5);
    tick();
    #1 chk("ff_idle_busy", busy_o, 0);

    // flush with two outstanding and one queued
    cmd_ready_i = 1'b1;
    offer(IX1, 64'd20, 3'd1);
    tick();
    offer(IX1, 64'd21, 3'd2);
    tick();
    offer(IX1, 64'd22, 3'd3);
    tick();
    cmd_ready_i = 1'b0;
    offer(IX1, 64'd23, 3'd4);
    flush_i = 1'b1;
    #1 chk("fl_reject", rocc_ready_o, 0);
    chk("fl_queued", cmd_rs1_o, 22);
    tick();
    flush_i = 1'b0; rocc_valid_i = 1'b0;
    #1 chk("fl_cv", cmd_valid_o, 0);
    chk("fl_drain_rr", rocc_ready_o, 0);
    chk("fl_drain_pr", resp_ready_o, 1);
    chk("fl_busy", busy_o, 1);
    tick();
    resp_valid_i = 1'b1; resp_data_i = 64'h55;
    #1 chk("fl_drop0", wb_valid_o, 0);
    tick();
    #1 chk("fl_drop1", wb_valid_o, 0);
    chk("fl_still_drain", rocc_ready_o, 0);
    tick();
    resp_valid_i = 1'b0;
    #1 chk("fl_run_rr", rocc_ready_o, 1);
    chk("fl_run_busy", busy_o, 0);

    // reset abandons an in-flight response
    cmd_ready_i = 1'b1;
    offer(IX1, 64'd30, 3'd6);
    tick();
    rocc_valid_i = 1'b0;
    tick();
    cmd_ready_i = 1'b0; rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1 chk("mr_busy", busy_o, 0);
    chk("mr_rr", rocc_ready_o, 0);
    chk("mr_pr", resp_ready_o, 0);
    tick();
    resp_valid_i = 1'b1; resp_data_i = 64'h77;
    #1 chk("mr_pr1", resp_ready_o, 1);
    chk("mr_drop", wb_valid_o, 0);
    tick();
    resp_valid_i = 1'b0;

    // three commands, each stalled two cycles
    for (int i = 0; i < 3; i++) begin
      offer(IX0, 64'(40 + i), 3'(i));
      tick();
      rocc_valid_i = 1'b0;
      tick();
      tick();
      cmd_ready_i = 1'b1;
      tick();
      cmd_ready_i = 1'b0;
    end
    #1;
`ifdef ROCC_DISPATCH_PERF_EN
    chk("perf_cmd", perf_cmd_o, 3);
    chk("perf_stall", perf_stall_o, 6);
`else
    chk("perf_cmd_off", perf_cmd_o, 0);
    chk("perf_stall_off", perf_stall_o, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
